// File: rtl/blink_mask_pkg.sv
// Shared clock-display definitions: FSM state encoding, setting codes and
// digit-pair layout used by the blink, mode-setting and display-mux blocks.
package blink_mask_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SHOW   = 2'd1,
        ST_HIDE   = 2'd2,
        ST_HOLD   = 2'd3
    } blink_state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'd0,
        MODE_TIME_SET  = 2'd1,
        MODE_ALARM_SET = 2'd2,
        MODE_RESERVED  = 2'd3
    } setting_mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2,
        POS_NONE = 2'd3
    } setting_pos_t;

    localparam int DIGITS   = 6;
    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 2;
    localparam int HOUR_LSB = 4;

    localparam logic [DIGITS-1:0] ALL_DIGITS_ON = '1;

    // Digit enables with the pair of the given field blanked; POS_NONE blanks nothing.
    function automatic logic [DIGITS-1:0] field_blank_mask(input setting_pos_t pos);
        logic [DIGITS-1:0] m;
        m = ALL_DIGITS_ON;
        case (pos)
            POS_SEC:  m[SEC_LSB  +: 2] = 2'b00;
            POS_MIN:  m[MIN_LSB  +: 2] = 2'b00;
            POS_HOUR: m[HOUR_LSB +: 2] = 2'b00;
            default:  m = ALL_DIGITS_ON;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/blink_mask_sync2.sv
// Generic two-flop synchronizer for bringing a level signal into the local
// clock domain; reused for other asynchronous buttons.
module blink_mask_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops use an async active-low reset and non-blocking assignments so
    // every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/blink_mask.sv
// Setting-mode blink controller: blinks the selected digit pair, holding it
// steadily visible while the user is editing that field.
module blink_mask
    import blink_mask_pkg::*;
#(
    parameter int PHASE_TICKS = 4,
    parameter int HOLD_TICKS  = 8,
    parameter int CNT_W       = 4
) (
    input  logic              blink_on_clk,
    input  logic              rst_n,
    input  logic [1:0]        setting_mode,
    input  logic [1:0]        setting_position,
    input  logic              i_edit_active,
    output logic [DIGITS-1:0] o_digit_mask,
    output logic              o_blink_phase,
    output logic [1:0]        o_state
);

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);

    setting_mode_t     mode_q;
    setting_pos_t      pos_q;
    setting_pos_t      pos_prev;
    logic              edit_s;
    blink_state_t      state_q;
    blink_state_t      state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DIGITS-1:0] mask_d;
    logic              phase_d;
    logic              blink_en;
    logic              pos_changed;

    blink_mask_sync2 u_edit_sync (
        .clk   (blink_on_clk),
        .rst_n (rst_n),
        .d     (i_edit_active),
        .q     (edit_s)
    );

    assign blink_en    = (mode_q == MODE_TIME_SET) || (mode_q == MODE_ALARM_SET);
    assign pos_changed = (pos_q != pos_prev);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (!blink_en) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
                ST_SHOW, ST_HIDE: begin
                    if (edit_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LAST;
                    end else if (pos_changed) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else if (cnt_q == PHASE_LAST) begin
                        state_d = (state_q == ST_SHOW) ? ST_HIDE : ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (edit_s) begin
                        cnt_d = HOLD_LAST;
                    end else if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs follow the state being entered so they line up with o_state.
        phase_d = (state_d == ST_HIDE);
        mask_d  = phase_d ? field_blank_mask(pos_q) : ALL_DIGITS_ON;
    end

    always_ff @(posedge blink_on_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_NORMAL;
            pos_q         <= POS_NONE;
            pos_prev      <= POS_NONE;
            state_q       <= ST_NORMAL;
            cnt_q         <= '0;
            o_digit_mask  <= ALL_DIGITS_ON;
            o_blink_phase <= 1'b0;
        end else begin
            mode_q        <= setting_mode_t'(setting_mode);
            pos_q         <= setting_pos_t'(setting_position);
            pos_prev      <= pos_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            o_digit_mask  <= mask_d;
            o_blink_phase <= phase_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_blink_mask.sv
// Randomized self-checking bench for blink_mask against a phase-timer model.
module tb_blink_mask;

    localparam int PHASE_TICKS = 4;
    localparam int HOLD_TICKS  = 8;
    localparam int CNT_W       = 4;

    localparam int K_NORMAL = 0;
    localparam int K_SHOW   = 1;
    localparam int K_HIDE   = 2;
    localparam int K_HOLD   = 3;

    logic       blink_on_clk = 1'b0;
    logic       rst_n;
    logic [1:0] setting_mode;
    logic [1:0] setting_position;
    logic       i_edit_active;
    logic [5:0] o_digit_mask;
    logic       o_blink_phase;
    logic [1:0] o_state;

    int errors = 0;
    int checks = 0;

    // Model state: pipelined input copies plus the visible phase and ticks left in it.
    int m_mode_q, m_pos_q, m_pos_prev, m_e1, m_es;
    int m_kind, m_left;
    logic [5:0] m_mask;
    logic       m_phase;

    blink_mask #(
        .PHASE_TICKS (PHASE_TICKS),
        .HOLD_TICKS  (HOLD_TICKS),
        .CNT_W       (CNT_W)
    ) dut (
        .blink_on_clk     (blink_on_clk),
        .rst_n            (rst_n),
        .setting_mode     (setting_mode),
        .setting_position (setting_position),
        .i_edit_active    (i_edit_active),
        .o_digit_mask     (o_digit_mask),
        .o_blink_phase    (o_blink_phase),
        .o_state          (o_state)
    );

    always #5 blink_on_clk = ~blink_on_clk;

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_mode_q   = 0;
        m_pos_q    = 3;
        m_pos_prev = 3;
        m_e1       = 0;
        m_es       = 0;
        m_kind     = K_NORMAL;
        m_left     = 0;
        m_mask     = 6'h3f;
        m_phase    = 1'b0;
    endtask

    task automatic model_step(input int md, input int ps, input int ed);
        bit blink;
        int old_pos;
        blink   = (m_mode_q == 1) || (m_mode_q == 2);
        old_pos = m_pos_q;
        if (!blink) begin
            m_kind = K_NORMAL;
        end else if (m_kind == K_NORMAL) begin
            m_kind = K_SHOW;
            m_left = PHASE_TICKS;
        end else if (m_kind == K_HOLD) begin
            if (m_es != 0) begin
                m_left = HOLD_TICKS;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_kind = K_SHOW;
                    m_left = PHASE_TICKS;
                end
            end
        end else if (m_es != 0) begin
            m_kind = K_HOLD;
            m_left = HOLD_TICKS;
        end else if (m_pos_q != m_pos_prev) begin
            m_kind = K_SHOW;
            m_left = PHASE_TICKS;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_kind = (m_kind == K_SHOW) ? K_HIDE : K_SHOW;
                m_left = PHASE_TICKS;
            end
        end
        m_phase = (m_kind == K_HIDE);
        if (m_phase && old_pos != 3)
            m_mask = 6'h3f & ~(6'h03 << (2 * old_pos));
        else
            m_mask = 6'h3f;
        m_pos_prev = m_pos_q;
        m_pos_q    = ps;
        m_mode_q   = md;
        m_es       = m_e1;
        m_e1       = ed;
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".mask"},  {2'b00, o_digit_mask}, {2'b00, m_mask});
        check({ctx, ".phase"}, {7'd0, o_blink_phase}, {7'd0, m_phase});
        check({ctx, ".state"}, {6'd0, o_state},       8'(m_kind));
    endtask

    task automatic tick(input string ctx, input int md, input int ps, input int ed);
        setting_mode     = md[1:0];
        setting_position = ps[1:0];
        i_edit_active    = ed[0];
        @(posedge blink_on_clk);
        model_step(md, ps, ed);
        #1;
        compare_all(ctx);
    endtask

    task automatic ticks(input string ctx, input int n, input int md, input int ps, input int ed);
        for (int i = 0; i < n; i++) tick(ctx, md, ps, ed);
    endtask

    task automatic until_hide(input string ctx, input int md, input int ps);
        for (int i = 0; i < 3 * PHASE_TICKS + HOLD_TICKS && m_kind != K_HIDE; i++)
            tick(ctx, md, ps, 0);
        check({ctx, ".reached_hide"}, 8'(m_kind), 8'(K_HIDE));
    endtask

    // Reset asserted and released between clock edges.
    task automatic async_reset(input string ctx);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all({ctx, ".immediate"});
        @(posedge blink_on_clk);
        #1;
        compare_all({ctx, ".held"});
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int md, ps, ed;
        rst_n            = 1'b0;
        setting_mode     = 2'd0;
        setting_position = 2'd0;
        i_edit_active    = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        compare_all("reset");
        ticks("normal_idle", 10, 0, 0, 0);

        ticks("blink_min", 20, 1, 1, 0);

        until_hide("to_hide_hour", 1, 2);
        ticks("edit_hold", 7, 1, 2, 1);
        ticks("edit_release", 14, 1, 2, 0);

        until_hide("to_hide_sec", 1, 0);
        tick("hide_sec", 1, 0, 0);
        ticks("pos_change", 10, 1, 2, 0);

        ticks("hold_again", 6, 1, 2, 1);
        ticks("mode_exit", 6, 0, 2, 1);
        ticks("reserved_mode", 4, 3, 1, 0);

        until_hide("to_hide_alarm", 2, 1);
        async_reset("rst_mid_hide");
        ticks("resume_alarm", 8, 2, 1, 0);

        md = 1; ps = 0; ed = 0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 39) == 0) md = $urandom_range(0, 3);
            if ($urandom_range(0, 14) == 0) ps = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0)  ed = 1 - ed;
            tick("random", md, ps, ed);
            if (i % 300 == 299) async_reset("rst_random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
